// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_CORR    = 4'd6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CORR,
        S_DONE
    } state_t;

    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

    function automatic logic digit_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Request/result bundle of bcd_serial_addsub; master drives the request, slave returns the result.
interface bcd_serial_addsub_if #(
    parameter int NR_DIGITS = 4
);
    localparam int WIDTH = 4 * NR_DIGITS;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] nr1;
    logic [WIDTH-1:0] nr2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             neg;
    logic             err;

    modport master (
        output start, op, nr1, nr2,
        input  busy, done, result, carry_out, neg, err
    );

    modport slave (
        input  start, op, nr1, nr2,
        output busy, done, result, carry_out, neg, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction; reused for every digit position.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = 4'(raw + {1'b0, BCD_CORR});
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD add/subtract, one digit per clock, LSD first.
// Define BCD_SIGN_MAG_EN to return negative differences as sign + magnitude instead of ten's complement.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter  int NR_DIGITS = 4,
    localparam int WIDTH     = 4 * NR_DIGITS
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_addsub_if.slave   bus
);

    localparam int IDX_W = (NR_DIGITS > 1) ? $clog2(NR_DIGITS) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_next;
    logic               op_q;
    logic               carry_q;
    logic               carry_out_q;
    logic               neg_q;
    logic               err_q;
    logic               operands_bad;
    logic               last_digit;
    logic [3:0]         slice_b;
    logic [3:0]         slice_sum;
    logic               slice_cout;

    always_comb begin
        operands_bad = 1'b0;
        for (int i = 0; i < NR_DIGITS; i++) begin
            if (digit_invalid(bus.nr1[4*i +: 4]) || digit_invalid(bus.nr2[4*i +: 4]))
                operands_bad = 1'b1;
        end
    end

    // Subtraction is A + nines(B) + 1; the correction pass reuses this with A forced to zero.
    assign slice_b    = (op_q == OP_SUB) ? nines_comp(b_sr[3:0]) : b_sr[3:0];
    assign last_digit = (idx == IDX_W'(NR_DIGITS - 1));

    bcd_digit_add u_digit (
        .a    (a_sr[3:0]),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New digits enter at the top, so after NR_DIGITS shifts digit 0 sits at the bottom.
    assign res_next = (res_q >> BCD_DIGIT_W) | (WIDTH'(slice_sum) << (WIDTH - BCD_DIGIT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nxt = operands_bad ? S_DONE : S_CALC;
            end
            S_CALC: begin
`ifdef BCD_SIGN_MAG_EN
                if (last_digit)
                    state_nxt = ((op_q == OP_SUB) && !slice_cout) ? S_CORR : S_DONE;
`else
                if (last_digit)
                    state_nxt = S_DONE;
`endif
            end
`ifdef BCD_SIGN_MAG_EN
            S_CORR: begin
                if (last_digit)
                    state_nxt = S_DONE;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            res_q       <= '0;
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q        <= bus.op;
                        a_sr        <= bus.nr1;
                        b_sr        <= bus.nr2;
                        idx         <= '0;
                        carry_q     <= bus.op;
                        carry_out_q <= 1'b0;
                        neg_q       <= 1'b0;
                        res_q       <= '0;
                        err_q       <= operands_bad;
                    end
                end
                S_CALC: begin
                    res_q   <= res_next;
                    a_sr    <= a_sr >> BCD_DIGIT_W;
                    b_sr    <= b_sr >> BCD_DIGIT_W;
                    carry_q <= slice_cout;
                    idx     <= idx + IDX_W'(1);
                    if (last_digit) begin
                        idx         <= '0;
                        carry_out_q <= slice_cout;
                        neg_q       <= (op_q == OP_SUB) && !slice_cout;
`ifdef BCD_SIGN_MAG_EN
                        // Prime the second pass: 0 - result = nines(result) + 1.
                        if ((op_q == OP_SUB) && !slice_cout) begin
                            a_sr    <= '0;
                            b_sr    <= res_next;
                            carry_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef BCD_SIGN_MAG_EN
                S_CORR: begin
                    res_q   <= res_next;
                    a_sr    <= a_sr >> BCD_DIGIT_W;
                    b_sr    <= b_sr >> BCD_DIGIT_W;
                    carry_q <= slice_cout;
                    idx     <= last_digit ? '0 : idx + IDX_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = carry_out_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;

endmodule
